// File: rtl/mul_repadd_ctrl_if.sv
// Control bundle between the repeated-addition controller and its datapath/operand source.
// master = controller side, slave = datapath plus operand source side.
interface mul_repadd_ctrl_if #(
    parameter int W = 8
);
    logic         start;
    logic         abort;
    logic         data_valid;
    logic         eqz;
    logic         data_ready;
    logic         ldA;
    logic         ldB;
    logic         clrs;
    logic         ldS;
    logic         decB;
    logic         busy;
    logic         done;
    logic [W-1:0] iter_cnt;

    modport master (
        input  start, abort, data_valid, eqz,
        output data_ready, ldA, ldB, clrs, ldS, decB, busy, done, iter_cnt
    );

    modport slave (
        output start, abort, data_valid, eqz,
        input  data_ready, ldA, ldB, clrs, ldS, decB, busy, done, iter_cnt
    );
endinterface

// File: rtl/mul_repadd_ctrl.sv
// Sequencer for the repeated-addition multiplier: loads A then B, loops add/decrement until B==0.
// Latency: done at cycle n+4 after start (n = B), plus one cycle per data_valid-low cycle while loading.
// Backpressure: operands accepted only when data_ready && data_valid; start ignored while busy.
module mul_repadd_ctrl #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mul_repadd_ctrl_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        LDA,
        LDB,
        ADD,
        DONE
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] iter_q;

    logic data_ready;
    logic ld_a;
    logic ld_b;
    logic clr_s;
    logic ld_s;
    logic dec_b;
    logic done;
    logic clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort is tested first in every busy loading/looping state so it wins over data_valid and eqz.
    always_comb begin
        state_d    = state_q;
        data_ready = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        clr_s      = 1'b0;
        ld_s       = 1'b0;
        dec_b      = 1'b0;
        done       = 1'b0;
        clr_cnt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LDA;
                    clr_cnt = 1'b1;
                end
            end
            LDA: begin
                data_ready = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.data_valid) begin
                    ld_a    = 1'b1;
                    clr_s   = 1'b1;
                    state_d = LDB;
                end
            end
            LDB: begin
                data_ready = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.data_valid) begin
                    ld_b    = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (!bus.eqz) begin
                    ld_s  = 1'b1;
                    dec_b = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Counts issued adds; wraps naturally at 2^W and freezes on abort since ld_s drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_q <= '0;
        end else if (clr_cnt) begin
            iter_q <= '0;
        end else if (ld_s) begin
            iter_q <= iter_q + 1'b1;
        end
    end

    assign bus.data_ready = data_ready;
    assign bus.ldA        = ld_a;
    assign bus.ldB        = ld_b;
    assign bus.clrs       = clr_s;
    assign bus.ldS        = ld_s;
    assign bus.decB       = dec_b;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done;
    assign bus.iter_cnt   = iter_q;

endmodule
